ring_station_arbiter: RTL and testbench
=======================================

Name: ring_station_arbiter

Overview:
- Token-ring access controller for one ring station. It shares the station's ring slot between NREQ local requesters, such as I cache, D cache and DMA/IO.
- It captures the TOKEN, grants slots round-robin with a bounded hold time, then releases the TOKEN.
- It nullifies slots that return to their originating station, and it applies local rewrites to passing slots.
- Sits between the upstream and downstream ring segments of a core and replaces the core's inline token logic.

Parameters:
- STATION_ID, 1, value placed in slot_source_out on generated slots and used to detect returning slots; must be non-zero.
- NREQ, 3, number of local requesters (2..8).
- TSIZE, 4, slot type field width.
- SSIZE, 4, slot source field width.
- TYPE_NULL, 0, encoding of a NULL slot.
- TYPE_TOKEN, 1, encoding of a TOKEN slot.
- MAXHOLD, 8, maximum slots granted per token capture; 0 means unlimited.
- INJECT_TOKEN, 0, when 1 this station emits the single initial TOKEN after reset.

Ports:
- clk  in  1  clock.
- reset_n  in  1  asynchronous active-low reset.
- slot_type_in  in  TSIZE  upstream slot type.
- slot_source_in  in  SSIZE  upstream slot source.
- slot_data_in  in  32  upstream slot data.
- slot_type_out  out  TSIZE  downstream slot type.
- slot_source_out  out  SSIZE  downstream slot source.
- slot_data_out  out  32  downstream slot data.
- req  in  NREQ  per-requester slot request; held until acked.
- ack  out  NREQ  one-hot grant; the acked requester's slot is emitted this cycle.
- dev_drive  in  NREQ  requester rewrites the passing slot this cycle (no grant needed).
- dev_slot_type  in  NREQ*TSIZE  per-requester slot type, requester i at [i*TSIZE +: TSIZE].
- dev_slot_data  in  NREQ*32  per-requester slot data, requester i at [i*32 +: 32].
- have_token  out  1  registered; high while the station holds the token (state OWN).

Behaviour:
- Clocking and reset: one clock, clk; reset is asynchronous and active-low on reset_n.
- Registered state:
  - state: INIT, WAIT or OWN.
  - rr_ptr: log2(NREQ) bits.
  - hold_cnt: 8 bits.
- Reset (reset_n low):
  - state <= INIT if INJECT_TOKEN, else WAIT; rr_ptr <= 0; hold_cnt <= 0.
  - Outputs are forced combinationally while reset_n is low: ack = 0, slot_type_out = TYPE_NULL, slot_source_out = 0, slot_data_out = 0, have_token = 0.
  - Reset mid-OWN destroys the token. Only an INJECT_TOKEN station re-creates it.
- INIT: emit TYPE_TOKEN with source 0 and data 0 for exactly one cycle, then go to WAIT. ack = 0 in INIT.
- can_xmit = (WAIT && slot_type_in==TYPE_TOKEN && |req) || OWN.
  - The grant therefore occurs in the same cycle the token arrives; latency from token arrival to first slot is 0 cycles.
- Grant: when can_xmit && |req && (MAXHOLD==0 || hold_cnt<MAXHOLD):
  - ack is one-hot to the first asserted req at or after rr_ptr, searching cyclically upward.
  - Slot out = that requester's dev_slot_type/dev_slot_data, with source STATION_ID.
  - Next-state updates:
    - rr_ptr <= (granted+1) mod NREQ.
    - hold_cnt <= hold_cnt+1 if entering from OWN, or 1 if entering from WAIT; saturate at 255.
    - state <= OWN.
- Release: in OWN when !|req, or when MAXHOLD!=0 && hold_cnt==MAXHOLD:
  - Emit TYPE_TOKEN with source 0 and data 0; ack = 0.
  - state <= WAIT; hold_cnt <= 0.
  - The emitted token passes downstream, so this station cannot recapture it in the same cycle.
- WAIT, token arrives, no req: pass the token unchanged.
- In OWN, the incoming slot is always discarded and overwritten. Its content is unused.
- Rewrite: when not granting and not in INIT/release, and any dev_drive is set:
  - The lowest-index driver's type/data replace the slot.
  - slot_source_out = slot_source_in, except it becomes 0 if the slot is a returning slot (nullify case).
  - Rewrite of a TOKEN slot is ignored; a TOKEN always passes intact.
- Nullify: when not driving, not holding and slot_source_in==STATION_ID, emit TYPE_NULL with source 0 and data 0.
- Output priority: reset > INIT > grant > release > rewrite > nullify > pass-through.
- Pass-through is combinational: zero-latency inputs to outputs. Only state is registered.
- A requester dropping req without ack is legal; the arbiter never acks a deasserted req.

Test Plan:
- Token circulation with INJECT_TOKEN=1, loopback ring, req=0:
  - Cycle after reset_n rises: TYPE_TOKEN out, source 0.
  - Then the token passes each cycle it returns; have_token stays 0.
- Round-robin fairness, NREQ=3, req=3'b111 held, MAXHOLD=0, token arrives:
  - ack sequence 001,010,100,001… on consecutive cycles; source_out=STATION_ID each cycle.
  - When req falls to 0: TOKEN emitted next, state WAIT.
- Hold limit, MAXHOLD=2, req=3'b001 held:
  - Two grants, then a TOKEN cycle with ack=0, then WAIT.
  - Regrant occurs only when the next TOKEN arrives.
- Nullify and pass-through, WAIT, no req:
  - Input type 5, source STATION_ID, data 0xDEADBEEF -> out TYPE_NULL, source 0, data 0.
  - Same slot with source 2 -> passed unchanged.
- Rewrite priority, WAIT, dev_drive=3'b110, passing slot type 3, source 2:
  - Out = requester 1's type/data with source 2.
  - When the input is TYPE_TOKEN, the token passes unchanged.
- Asynchronous reset mid-OWN: drop reset_n mid-cycle:
  - ack=0, NULL out and have_token=0 immediately, without waiting for a clock edge.
  - After release, INIT emits one TOKEN.

Source files
------------

// File: rtl/ring_station_arbiter.sv
// ring_station_arbiter
//   Token-ring access controller for one ring station. Captures the TOKEN,
//   grants the station's ring slot round-robin among NREQ local requesters
//   with a bounded hold time, then releases the TOKEN. Slots returning to
//   this station are nullified; local devices may rewrite passing slots.
//
// Ports:
//   clk, reset_n                       clock, asynchronous active-low reset
//   slot_type/source/data_in           upstream ring slot
//   slot_type/source/data_out          downstream ring slot (combinational)
//   req[NREQ]                          per-requester slot request
//   ack[NREQ]                          one-hot grant, slot emitted this cycle
//   dev_drive[NREQ]                    requester rewrites the passing slot
//   dev_slot_type[NREQ*TSIZE]          requester i at [i*TSIZE +: TSIZE]
//   dev_slot_data[NREQ*32]             requester i at [i*32 +: 32]
//   have_token                         high while the station holds the token
module ring_station_arbiter #(
    parameter int unsigned STATION_ID   = 1,
    parameter int unsigned NREQ         = 3,
    parameter int unsigned TSIZE        = 4,
    parameter int unsigned SSIZE        = 4,
    parameter int unsigned TYPE_NULL    = 0,
    parameter int unsigned TYPE_TOKEN   = 1,
    parameter int unsigned MAXHOLD      = 8,
    parameter int unsigned INJECT_TOKEN = 0
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [TSIZE-1:0]      slot_type_in,
    input  logic [SSIZE-1:0]      slot_source_in,
    input  logic [31:0]           slot_data_in,
    output logic [TSIZE-1:0]      slot_type_out,
    output logic [SSIZE-1:0]      slot_source_out,
    output logic [31:0]           slot_data_out,
    input  logic [NREQ-1:0]       req,
    output logic [NREQ-1:0]       ack,
    input  logic [NREQ-1:0]       dev_drive,
    input  logic [NREQ*TSIZE-1:0] dev_slot_type,
    input  logic [NREQ*32-1:0]    dev_slot_data,
    output logic                  have_token
);

    localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [TSIZE-1:0] T_NULL  = TSIZE'(TYPE_NULL);
    localparam logic [TSIZE-1:0] T_TOKEN = TSIZE'(TYPE_TOKEN);
    localparam logic [SSIZE-1:0] MY_ID   = SSIZE'(STATION_ID);
    localparam logic [7:0]       HOLD_MAX = 8'(MAXHOLD);

    typedef enum logic [1:0] {ST_INIT, ST_WAIT, ST_OWN} state_t;

    state_t        state, state_nxt;
    logic [PW-1:0] rr_ptr, rr_nxt;
    logic [7:0]    hold_cnt, hold_nxt;

    logic             gnt_found;
    logic [PW-1:0]    gnt_idx;
    logic [TSIZE-1:0] gnt_type;
    logic [31:0]      gnt_data;
    logic             drv_found;
    logic [TSIZE-1:0] drv_type;
    logic [31:0]      drv_data;
    logic             is_token, returning, can_xmit, hold_ok, grant;

    // Cyclic search starting at rr_ptr; lowest-index search for rewriters.
    always_comb begin
        int unsigned idx;
        gnt_found = 1'b0;
        gnt_idx   = '0;
        gnt_type  = '0;
        gnt_data  = '0;
        drv_found = 1'b0;
        drv_type  = '0;
        drv_data  = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            idx = (32'(rr_ptr) + i) % NREQ;
            if (!gnt_found && req[idx]) begin
                gnt_found = 1'b1;
                gnt_idx   = PW'(idx);
                gnt_type  = dev_slot_type[idx*TSIZE +: TSIZE];
                gnt_data  = dev_slot_data[idx*32 +: 32];
            end
            if (!drv_found && dev_drive[i]) begin
                drv_found = 1'b1;
                drv_type  = dev_slot_type[i*TSIZE +: TSIZE];
                drv_data  = dev_slot_data[i*32 +: 32];
            end
        end
    end

    assign is_token  = (slot_type_in == T_TOKEN);
    assign returning = (slot_source_in == MY_ID);
    assign can_xmit  = ((state == ST_WAIT) && is_token && (|req)) || (state == ST_OWN);
    assign hold_ok   = (MAXHOLD == 0) || (hold_cnt < HOLD_MAX);
    assign grant     = can_xmit && (|req) && hold_ok;

    always_comb begin
        state_nxt       = state;
        rr_nxt          = rr_ptr;
        hold_nxt        = hold_cnt;
        ack             = '0;
        slot_type_out   = slot_type_in;
        slot_source_out = slot_source_in;
        slot_data_out   = slot_data_in;

        if (state == ST_INIT) begin
            slot_type_out   = T_TOKEN;
            slot_source_out = '0;
            slot_data_out   = '0;
            state_nxt       = ST_WAIT;
        end else if (grant) begin
            ack             = NREQ'(1) << gnt_idx;
            slot_type_out   = gnt_type;
            slot_source_out = MY_ID;
            slot_data_out   = gnt_data;
            rr_nxt          = (32'(gnt_idx) == NREQ - 1) ? '0 : gnt_idx + 1'b1;
            if (state == ST_OWN)
                hold_nxt = (hold_cnt == 8'hFF) ? hold_cnt : hold_cnt + 8'd1;
            else
                hold_nxt = 8'd1;
            state_nxt = ST_OWN;
        end else if (state == ST_OWN) begin
            // In OWN without a grant, either req dropped or the hold limit hit.
            slot_type_out   = T_TOKEN;
            slot_source_out = '0;
            slot_data_out   = '0;
            hold_nxt        = '0;
            state_nxt       = ST_WAIT;
        end else if (drv_found && !is_token) begin
            slot_type_out   = drv_type;
            slot_data_out   = drv_data;
            slot_source_out = returning ? '0 : slot_source_in;
        end else if (returning) begin
            slot_type_out   = T_NULL;
            slot_source_out = '0;
            slot_data_out   = '0;
        end

        if (!reset_n) begin
            ack             = '0;
            slot_type_out   = T_NULL;
            slot_source_out = '0;
            slot_data_out   = '0;
        end
    end

    assign have_token = reset_n && (state == ST_OWN);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= (INJECT_TOKEN != 0) ? ST_INIT : ST_WAIT;
            rr_ptr   <= '0;
            hold_cnt <= '0;
        end else begin
            state    <= state_nxt;
            rr_ptr   <= rr_nxt;
            hold_cnt <= hold_nxt;
        end
    end

endmodule

// File: tb/tb_ring_station_arbiter.sv
module tb_ring_station_arbiter;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [3:0]  tb_type;
    logic [3:0]  tb_src;
    logic [31:0] tb_data;
    logic        loop_en;
    logic [2:0]  req_a, req_b;
    logic [2:0]  dev_drive;
    logic [11:0] dev_slot_type;
    logic [95:0] dev_slot_data;

    // DUT A: token injector with a one-stage loopback ring segment
    logic [3:0]  a_type_in, a_type_out, ring_type;
    logic [3:0]  a_src_in, a_src_out, ring_src;
    logic [31:0] a_data_in, a_data_out, ring_data;
    logic [2:0]  a_ack;
    logic        a_have;

    // DUT B: unlimited hold, driven directly by the bench
    logic [3:0]  b_type_out, b_src_out;
    logic [31:0] b_data_out;
    logic [2:0]  b_ack;
    logic        b_have;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        ring_type <= a_type_out;
        ring_src  <= a_src_out;
        ring_data <= a_data_out;
    end

    assign a_type_in = loop_en ? ring_type : tb_type;
    assign a_src_in  = loop_en ? ring_src  : tb_src;
    assign a_data_in = loop_en ? ring_data : tb_data;

    ring_station_arbiter #(
        .STATION_ID(1), .NREQ(3), .TSIZE(4), .SSIZE(4), .TYPE_NULL(0),
        .TYPE_TOKEN(1), .MAXHOLD(2), .INJECT_TOKEN(1)
    ) dut_a (
        .clk(clk), .reset_n(reset_n),
        .slot_type_in(a_type_in), .slot_source_in(a_src_in), .slot_data_in(a_data_in),
        .slot_type_out(a_type_out), .slot_source_out(a_src_out), .slot_data_out(a_data_out),
        .req(req_a), .ack(a_ack), .dev_drive(dev_drive),
        .dev_slot_type(dev_slot_type), .dev_slot_data(dev_slot_data),
        .have_token(a_have)
    );

    ring_station_arbiter #(
        .STATION_ID(1), .NREQ(3), .TSIZE(4), .SSIZE(4), .TYPE_NULL(0),
        .TYPE_TOKEN(1), .MAXHOLD(0), .INJECT_TOKEN(0)
    ) dut_b (
        .clk(clk), .reset_n(reset_n),
        .slot_type_in(tb_type), .slot_source_in(tb_src), .slot_data_in(tb_data),
        .slot_type_out(b_type_out), .slot_source_out(b_src_out), .slot_data_out(b_data_out),
        .req(req_b), .ack(b_ack), .dev_drive(dev_drive),
        .dev_slot_type(dev_slot_type), .dev_slot_data(dev_slot_data),
        .have_token(b_have)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_a(input string tag, input logic [2:0] ack, input logic [3:0] ty,
                         input logic [3:0] src, input logic [31:0] data, input logic have);
        chk({tag, ".a_ack"},  64'(a_ack),      64'(ack));
        chk({tag, ".a_type"}, 64'(a_type_out), 64'(ty));
        chk({tag, ".a_src"},  64'(a_src_out),  64'(src));
        chk({tag, ".a_data"}, 64'(a_data_out), 64'(data));
        chk({tag, ".a_have"}, 64'(a_have),     64'(have));
    endtask

    task automatic chk_b(input string tag, input logic [2:0] ack, input logic [3:0] ty,
                         input logic [3:0] src, input logic [31:0] data, input logic have);
        chk({tag, ".b_ack"},  64'(b_ack),      64'(ack));
        chk({tag, ".b_type"}, 64'(b_type_out), 64'(ty));
        chk({tag, ".b_src"},  64'(b_src_out),  64'(src));
        chk({tag, ".b_data"}, 64'(b_data_out), 64'(data));
        chk({tag, ".b_have"}, 64'(b_have),     64'(have));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset_n       = 1'b0;
        tb_type       = 4'd0;
        tb_src        = 4'd0;
        tb_data       = 32'd0;
        loop_en       = 1'b1;
        req_a         = 3'b000;
        req_b         = 3'b000;
        dev_drive     = 3'b000;
        dev_slot_type = {4'd10, 4'd9, 4'd8};
        dev_slot_data = {32'hA000_0002, 32'hA000_0001, 32'hA000_0000};

        // Reset state
        #3;
        chk_a("reset", 3'b000, 4'd0, 4'd0, 32'd0, 1'b0);
        chk_b("reset", 3'b000, 4'd0, 4'd0, 32'd0, 1'b0);
        tick(); tick();
        reset_n = 1'b1;

        // Token injection, then circulation through the loopback ring
        #3; chk_a("init_token", 3'b000, 4'd1, 4'd0, 32'd0, 1'b0);
        tick(); #3; chk_a("circ1", 3'b000, 4'd1, 4'd0, 32'd0, 1'b0);
        tick(); #3; chk_a("circ2", 3'b000, 4'd1, 4'd0, 32'd0, 1'b0);
        tick(); #3; chk_a("circ3", 3'b000, 4'd1, 4'd0, 32'd0, 1'b0);

        // Round-robin on B, unlimited hold
        tick(); tb_type = 4'd1; req_b = 3'b111;
        #3; chk_b("rr0", 3'b001, 4'd8,  4'd1, 32'hA000_0000, 1'b0);
        tick(); tb_type = 4'd5; tb_src = 4'd3; tb_data = 32'h1111_1111;
        #3; chk_b("rr1", 3'b010, 4'd9,  4'd1, 32'hA000_0001, 1'b1);
        tick(); #3; chk_b("rr2", 3'b100, 4'd10, 4'd1, 32'hA000_0002, 1'b1);
        tick(); #3; chk_b("rr3", 3'b001, 4'd8,  4'd1, 32'hA000_0000, 1'b1);
        tick(); req_b = 3'b000;
        #3; chk_b("rr_release", 3'b000, 4'd1, 4'd0, 32'd0, 1'b1);
        tick(); tb_type = 4'd0; tb_src = 4'd0; tb_data = 32'd0;
        #3; chk_b("rr_wait", 3'b000, 4'd0, 4'd0, 32'd0, 1'b0);

        // Hold limit on A (MAXHOLD=2), ring segment opened
        loop_en = 1'b0; tb_type = 4'd1; req_a = 3'b001;
        #3; chk_a("hold_g1", 3'b001, 4'd8, 4'd1, 32'hA000_0000, 1'b0);
        tick(); tb_type = 4'd0;
        #3; chk_a("hold_g2", 3'b001, 4'd8, 4'd1, 32'hA000_0000, 1'b1);
        tick(); #3; chk_a("hold_rel", 3'b000, 4'd1, 4'd0, 32'd0, 1'b1);
        tick(); #3; chk_a("hold_wait", 3'b000, 4'd0, 4'd0, 32'd0, 1'b0);
        tick(); tb_type = 4'd1;
        #3; chk_a("hold_regrant", 3'b001, 4'd8, 4'd1, 32'hA000_0000, 1'b0);
        tick(); tb_type = 4'd0; req_a = 3'b000;
        #3; chk_a("hold_drop", 3'b000, 4'd1, 4'd0, 32'd0, 1'b1);
        tick();

        // Nullify and pass-through on B in WAIT
        tb_type = 4'd5; tb_src = 4'd1; tb_data = 32'hDEAD_BEEF;
        #3; chk_b("nullify", 3'b000, 4'd0, 4'd0, 32'd0, 1'b0);
        tick(); tb_src = 4'd2;
        #3; chk_b("pass", 3'b000, 4'd5, 4'd2, 32'hDEAD_BEEF, 1'b0);

        // Rewrite priority
        tick(); dev_drive = 3'b110; tb_type = 4'd3; tb_src = 4'd2; tb_data = 32'h1234_5678;
        #3; chk_b("rewrite", 3'b000, 4'd9, 4'd2, 32'hA000_0001, 1'b0);
        tick(); tb_src = 4'd1;
        #3; chk_b("rewrite_ret", 3'b000, 4'd9, 4'd0, 32'hA000_0001, 1'b0);
        tick(); tb_type = 4'd1; tb_src = 4'd0; tb_data = 32'd0;
        #3; chk_b("rewrite_token", 3'b000, 4'd1, 4'd0, 32'd0, 1'b0);
        tick(); dev_drive = 3'b000;

        // Asynchronous reset while B owns the token (rr_ptr is 1 here)
        req_b = 3'b111;
        #3; chk_b("pre_rst_grant", 3'b010, 4'd9, 4'd1, 32'hA000_0001, 1'b0);
        tick(); tb_type = 4'd0;
        #3; chk_b("pre_rst_own", 3'b100, 4'd10, 4'd1, 32'hA000_0002, 1'b1);
        reset_n = 1'b0;
        #1; chk_b("async_rst", 3'b000, 4'd0, 4'd0, 32'd0, 1'b0);
        tick(); tick();
        reset_n = 1'b1;
        #3; chk_a("reinit_token", 3'b000, 4'd1, 4'd0, 32'd0, 1'b0);
        chk_b("post_rst_wait", 3'b000, 4'd0, 4'd0, 32'd0, 1'b0);
        tick(); #3; chk_a("reinit_once", 3'b000, 4'd0, 4'd0, 32'd0, 1'b0);
        tick(); tb_type = 4'd1;
        #3; chk_b("post_rst_rr", 3'b001, 4'd8, 4'd1, 32'hA000_0000, 1'b0);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
